alu_seq: RTL and testbench

- Issue/sequencing controller in front of the combinational 32-bit ALU.
- Accepts one operation at a time over a valid/ready handshake and drives the external ALU instance for single-cycle opcodes.
- Runs an internal iterative engine for MUL (0xb) and DIV (0xc), which the ALU does not implement.
- Returns result, overflow and condition code over a valid/ready output handshake.

---
 rtl/alu_seq.sv | 187 ++++++++++++++++++
 tb/tb_alu_seq.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/alu_seq.sv
// Issue/sequencing controller for the external combinational ALU, with an internal
// shift-add multiplier and restoring divider. Optional REM opcode via ALU_SEQ_REM_EN.
module alu_seq #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [3:0]       alu_op,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  input  logic [WIDTH-1:0] alu_result,
  input  logic             alu_ovf,
  input  logic [3:0]       alu_cond,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_ovf,
  output logic [3:0]       out_cond,
  output logic             out_illegal,
  output logic             busy
);

  localparam logic [3:0] OP_OUT = 4'h0, OP_SUB = 4'h3, OP_SRA = 4'ha,
                         OP_MUL = 4'hb, OP_DIV = 4'hc, OP_REM = 4'hd;
`ifdef ALU_SEQ_REM_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif
  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [2:0] {S_IDLE, S_EXEC, S_MUL, S_DIV, S_DONE} state_t;

  state_t               state_q, state_d;
  logic [3:0]           op_q, op_d, aop_q, aop_d, cond_q, cond_d;
  logic [WIDTH-1:0]     a_q, a_d, b_q, b_d, aa_q, aa_d, ab_q, ab_d, res_q, res_d;
  logic                 ovf_q, ovf_d, ill_q, ill_d;
  logic [2*WIDTH-1:0]   acc_q, acc_d;
  logic [CNT_W-1:0]     cnt_q, cnt_d;

  // acc holds {product hi, multiplier/product lo} in MUL and {remainder, quotient} in DIV.
  logic [WIDTH:0]       mul_sum, div_sh;
  logic [WIDTH+1:0]     div_diff;
  logic                 div_keep, div_unused;
  logic [WIDTH-1:0]     div_rem;
  logic [2*WIDTH-1:0]   mul_nxt, div_nxt;
  logic                 in_exec, in_div, is_rem;

  assign mul_sum    = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, a_q} : '0);
  assign mul_nxt    = {mul_sum, acc_q[WIDTH-1:1]};
  assign div_sh     = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
  assign div_diff   = {1'b0, div_sh} - {2'b00, b_q};
  assign div_keep   = ~div_diff[WIDTH+1];
  assign div_unused = div_diff[WIDTH];
  assign div_rem    = div_keep ? div_diff[WIDTH-1:0] : div_sh[WIDTH-1:0];
  assign div_nxt    = {div_rem, acc_q[WIDTH-2:0], div_keep};

  assign in_exec = (in_op == OP_OUT) || (in_op >= 4'h2 && in_op <= OP_SRA);
  assign in_div  = (in_op == OP_DIV) || (REM_EN && in_op == OP_REM);
  assign is_rem  = REM_EN && (op_q == OP_REM);

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    aop_d   = aop_q;
    aa_d    = aa_q;
    ab_d    = ab_q;
    res_d   = res_q;
    ovf_d   = ovf_q;
    cond_d  = cond_q;
    ill_d   = ill_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE: if (in_valid) begin
        op_d   = in_op;
        a_d    = in_a;
        b_d    = in_b;
        cnt_d  = '0;
        res_d  = '0;
        ovf_d  = 1'b0;
        cond_d = '0;
        ill_d  = 1'b0;
        if (in_exec) begin
          aop_d   = in_op;
          aa_d    = in_a;
          ab_d    = in_b;
          state_d = S_EXEC;
        end else if (in_op == OP_MUL) begin
          acc_d   = {{WIDTH{1'b0}}, in_b};
          state_d = S_MUL;
        end else if (in_div) begin
          acc_d   = {{WIDTH{1'b0}}, in_a};
          state_d = S_DIV;
        end else begin
          ill_d   = 1'b1;
          state_d = S_DONE;
        end
      end
      S_EXEC: begin
        res_d   = alu_result;
        ovf_d   = alu_ovf;
        cond_d  = (op_q == OP_SUB) ? alu_cond : 4'h0;
        state_d = S_DONE;
      end
      S_MUL: begin
        acc_d = mul_nxt;
        if (cnt_q == LAST) begin
          res_d   = mul_nxt[WIDTH-1:0];
          ovf_d   = |mul_nxt[2*WIDTH-1:WIDTH];
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      S_DIV: begin
        if (cnt_q == '0 && b_q == '0) begin
          res_d   = is_rem ? a_q : '1;
          ovf_d   = 1'b1;
          state_d = S_DONE;
        end else begin
          acc_d = div_nxt;
          if (cnt_q == LAST) begin
            res_d   = is_rem ? div_nxt[2*WIDTH-1:WIDTH] : div_nxt[WIDTH-1:0];
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_DONE: if (out_ready) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      aop_q   <= '0;
      aa_q    <= '0;
      ab_q    <= '0;
      res_q   <= '0;
      ovf_q   <= 1'b0;
      cond_q  <= '0;
      ill_q   <= 1'b0;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      aop_q   <= aop_d;
      aa_q    <= aa_d;
      ab_q    <= ab_d;
      res_q   <= res_d;
      ovf_q   <= ovf_d;
      cond_q  <= cond_d;
      ill_q   <= ill_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign busy        = (state_q != S_IDLE);
  assign out_valid   = (state_q == S_DONE);
  assign alu_op      = aop_q;
  assign alu_a       = aa_q;
  assign alu_b       = ab_q;
  assign out_result  = res_q;
  assign out_ovf     = ovf_q;
  assign out_cond    = cond_q;
  assign out_illegal = ill_q;

endmodule

// File: tb/tb_alu_seq.sv
// Bench for alu_seq: behavioural ALU, directed vector table, randomized ops vs. a
// plain-arithmetic reference model, backpressure and mid-operation reset sequences.
module tb_alu_seq;
  localparam int W = 32;
`ifdef ALU_SEQ_REM_EN
  localparam bit REM_EN = 1'b1;
`else
  localparam bit REM_EN = 1'b0;
`endif

  logic         clk = 1'b0, rst = 1'b1;
  logic         in_valid = 1'b0, in_ready, out_ready = 1'b0;
  logic [3:0]   in_op = '0, alu_op, alu_cond, out_cond;
  logic [W-1:0] in_a = '0, in_b = '0, alu_a, alu_b, alu_result, out_result;
  logic         alu_ovf, out_valid, out_ovf, out_illegal, busy;

  int checks = 0, errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .alu_op(alu_op), .alu_a(alu_a), .alu_b(alu_b),
    .alu_result(alu_result), .alu_ovf(alu_ovf), .alu_cond(alu_cond),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_ovf(out_ovf), .out_cond(out_cond), .out_illegal(out_illegal), .busy(busy)
  );

  typedef struct packed { logic [31:0] r; logic o; logic [3:0] c; } alu_t;
  typedef struct packed { logic [31:0] r; logic o; logic [3:0] c; logic il; logic [7:0] lat; } exp_t;
  typedef struct { logic [3:0] op; logic [31:0] a; logic [31:0] b; exp_t e; } vec_t;

  // Behavioural model of the external ALU; cond is produced for every op on purpose.
  function automatic alu_t alu_fn(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    alu_t x;
    x.r = '0;
    x.o = 1'b0;
    x.c = {a == b, a != b, $signed(a) > $signed(b), $signed(a) < $signed(b)};
    case (op)
      4'h0: x.r = a;
      4'h2: begin x.r = a + b; x.o = (a[31] == b[31]) && (x.r[31] != a[31]); end
      4'h3: begin x.r = a - b; x.o = (a[31] != b[31]) && (x.r[31] != a[31]); end
      4'h4: x.r = a & b;
      4'h5: x.r = a | b;
      4'h6: x.r = ~(a | b);
      4'h7: x.r = a ^ b;
      4'h8: x.r = a << b[4:0];
      4'h9: x.r = a >> b[4:0];
      4'ha: x.r = $signed(a) >>> b[4:0];
      default: begin x.r = 32'hDEADBEEF; x.o = 1'b1; end
    endcase
    return x;
  endfunction

  alu_t alu_now;
  assign alu_now    = alu_fn(alu_op, alu_a, alu_b);
  assign alu_result = alu_now.r;
  assign alu_ovf    = alu_now.o;
  assign alu_cond   = alu_now.c;

  function automatic exp_t model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t e;
    alu_t x;
    logic [63:0] p;
    e = '0;
    if (op == 4'h0 || (op >= 4'h2 && op <= 4'ha)) begin
      x = alu_fn(op, a, b);
      e.r = x.r; e.o = x.o; e.c = (op == 4'h3) ? x.c : 4'h0; e.lat = 8'd2;
    end else if (op == 4'hb) begin
      p = {32'b0, a} * {32'b0, b};
      e.r = p[31:0]; e.o = |p[63:32]; e.lat = 8'(W + 1);
    end else if (op == 4'hc || (REM_EN && op == 4'hd)) begin
      if (b == 0) begin
        e.r = (op == 4'hc) ? 32'hFFFFFFFF : a; e.o = 1'b1; e.lat = 8'd2;
      end else begin
        e.r = (op == 4'hc) ? a / b : a % b; e.lat = 8'(W + 1);
      end
    end else begin
      e.il = 1'b1; e.lat = 8'd1;
    end
    return e;
  endfunction

  function automatic vec_t mk(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                              input logic [31:0] r, input logic o, input logic [3:0] c,
                              input logic il, input int lat);
    vec_t v;
    v.op = op; v.a = a; v.b = b;
    v.e.r = r; v.e.o = o; v.e.c = c; v.e.il = il; v.e.lat = 8'(lat);
    return v;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // All tasks start and end on a falling edge.
  task automatic send(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int n;
    in_op = op; in_a = a; in_b = b; in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    if (!in_ready) begin chk("accept_timeout", 0, 1); in_valid = 1'b0; return; end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic collect(output exp_t got);
    int lat;
    lat = 1;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    if (!out_valid) chk("result_timeout", 0, 1);
    got.r = out_result; got.o = out_ovf; got.c = out_cond; got.il = out_illegal; got.lat = 8'(lat);
  endtask

  task automatic ack();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic run_cmp(input string nm, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input exp_t e);
    exp_t got;
    send(op, a, b);
    collect(got);
    ack();
    chk({nm, "_result"}, 64'(got.r), 64'(e.r));
    chk({nm, "_ovf"}, 64'(got.o), 64'(e.o));
    chk({nm, "_cond"}, 64'(got.c), 64'(e.c));
    chk({nm, "_illegal"}, 64'(got.il), 64'(e.il));
    chk({nm, "_latency"}, 64'(got.lat), 64'(e.lat));
  endtask

  vec_t vecs[$];
  exp_t g, snap;

  initial begin
    vecs.push_back(mk(4'h2, 32'h7FFFFFFF, 32'h1, 32'h80000000, 1, 4'h0, 0, 2));
    vecs.push_back(mk(4'h3, 32'd5, 32'd5, 32'h0, 0, 4'b1000, 0, 2));
    vecs.push_back(mk(4'h3, 32'd3, 32'd7, 32'hFFFFFFFC, 0, 4'b0101, 0, 2));
    vecs.push_back(mk(4'h4, 32'h0000F0F0, 32'h0000FF00, 32'h0000F000, 0, 4'h0, 0, 2));
    vecs.push_back(mk(4'ha, 32'h80000000, 32'd4, 32'hF8000000, 0, 4'h0, 0, 2));
    vecs.push_back(mk(4'h0, 32'h12345678, 32'h9, 32'h12345678, 0, 4'h0, 0, 2));
    vecs.push_back(mk(4'hb, 32'h00010000, 32'h00010000, 32'h0, 1, 4'h0, 0, 33));
    vecs.push_back(mk(4'hb, 32'd123, 32'd456, 32'd56088, 0, 4'h0, 0, 33));
    vecs.push_back(mk(4'hb, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000001, 1, 4'h0, 0, 33));
    vecs.push_back(mk(4'hc, 32'd100, 32'd7, 32'd14, 0, 4'h0, 0, 33));
    vecs.push_back(mk(4'hc, 32'hFFFFFFFF, 32'h1, 32'hFFFFFFFF, 0, 4'h0, 0, 33));
    vecs.push_back(mk(4'hc, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 4'h0, 0, 2));
    vecs.push_back(mk(4'h1, 32'd5, 32'd6, 32'h0, 0, 4'h0, 1, 1));
    vecs.push_back(mk(4'hf, 32'd5, 32'd6, 32'h0, 0, 4'h0, 1, 1));
    if (REM_EN) begin
      vecs.push_back(mk(4'hd, 32'd100, 32'd7, 32'd2, 0, 4'h0, 0, 33));
      vecs.push_back(mk(4'hd, 32'd77, 32'd0, 32'd77, 1, 4'h0, 0, 2));
    end else begin
      vecs.push_back(mk(4'hd, 32'd100, 32'd7, 32'h0, 0, 4'h0, 1, 1));
    end

    #1;
    chk("rst_in_ready", 64'(in_ready), 1);
    chk("rst_out_valid", 64'(out_valid), 0);
    chk("rst_busy", 64'(busy), 0);
    chk("rst_outputs", {out_result, out_ovf, out_cond, out_illegal}, 0);
    chk("rst_alu_if", {alu_op, alu_a, alu_b}, 0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    foreach (vecs[i]) run_cmp($sformatf("vec%0d_op%0h", i, vecs[i].op), vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].e);

    for (int i = 0; i < 40; i++) begin
      logic [3:0] op;
      logic [31:0] a, b;
      op = 4'($urandom_range(0, 15));
      a  = $urandom;
      b  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 20)) : $urandom;
      if (i % 8 == 0) b = 0;
      run_cmp($sformatf("rnd%0d_op%0h", i, op), op, a, b, model(op, a, b));
    end

    // Backpressure: result held while out_ready low; held request waits for IDLE.
    send(4'h2, 32'd1, 32'd2);
    collect(snap);
    in_op = 4'h3; in_a = 32'd9; in_b = 32'd4; in_valid = 1'b1;
    repeat (5) begin
      chk("bp_stable", {out_valid, out_result, out_ovf, out_cond, out_illegal},
          {1'b1, snap.r, snap.o, snap.c, snap.il});
      chk("bp_in_ready", 64'(in_ready), 0);
      @(negedge clk);
    end
    chk("bp_result", 64'(snap.r), 3);
    chk("bp_alu_if_held", {alu_op, alu_a, alu_b}, {4'h2, 32'd1, 32'd2});
    ack();
    chk("bp_post_ack_ready", {in_ready, out_valid, busy}, 3'b100);
    send(4'h3, 32'd9, 32'd4);
    collect(g);
    ack();
    chk("bp_next_result", 64'(g.r), 5);
    chk("bp_next_latency", 64'(g.lat), 2);

    // Reset mid-MUL aborts without producing a result.
    send(4'hb, 32'd1000, 32'd1000);
    repeat (9) @(negedge clk);
    rst = 1'b1;
    #1;
    chk("midrst_state", {in_ready, out_valid, busy}, 3'b100);
    chk("midrst_result", 64'(out_result), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    chk("midrst_no_result", 64'(out_valid), 0);
    run_cmp("post_rst_add", 4'h2, 32'd1, 32'd2, model(4'h2, 32'd1, 32'd2));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
